// File: rtl/encode_if.sv
// Request/response bundle for the RV32I instruction encoder: field inputs with
// valid/ready in, encoded word plus err and transfer count out.
interface encode_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic        err;
    logic [15:0] count;

    modport master (
        output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, inst, err, count
    );

    modport slave (
        input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, inst, err, count
    );
endinterface

// File: rtl/encode.sv
// RV32I field-to-word encoder with a 2-entry output FIFO of {inst, err}.
// Define ENCODE_RANGE_CHECK_EN to flag immediates the selected format cannot hold.
module encode (
    input  logic     clk,
    input  logic     reset,
    encode_if.slave  bus
);
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } entry_t;

    fmt_e        fmt;
    logic [31:0] enc_inst;
    logic        enc_err;

    always_comb begin
        unique case (bus.opcode)
            7'b0110011:             fmt = FMT_R;
            7'b0100011:             fmt = FMT_S;
            7'b1100011:             fmt = FMT_B;
            7'b0110111, 7'b0010111: fmt = FMT_U;
            7'b1101111:             fmt = FMT_J;
            default:                fmt = FMT_I;
        endcase
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        enc_inst = '0;
        unique case (fmt)
            FMT_R: enc_inst = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            FMT_S: enc_inst = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
            FMT_B: enc_inst = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                               bus.imm[4:1], bus.imm[11], bus.opcode};
            FMT_U: enc_inst = {bus.imm[31:12], bus.rd, bus.opcode};
            FMT_J: enc_inst = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                               bus.rd, bus.opcode};
            default: enc_inst = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        endcase
    end

`ifdef ENCODE_RANGE_CHECK_EN
    // Upper bits must replicate the format's top immediate bit; B/J also need even offsets.
    always_comb begin
        enc_err = 1'b0;
        unique case (fmt)
            FMT_I, FMT_S: enc_err = (bus.imm[31:12] != {20{bus.imm[11]}});
            FMT_B:        enc_err = (bus.imm[31:13] != {19{bus.imm[12]}}) || bus.imm[0];
            FMT_J:        enc_err = (bus.imm[31:21] != {11{bus.imm[20]}}) || bus.imm[0];
            FMT_U:        enc_err = (bus.imm[11:0] != 12'h000);
            default:      enc_err = 1'b0;
        endcase
    end
`else
    assign enc_err = 1'b0;
`endif

    entry_t      mem_q [2];
    entry_t      mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  occ_q, occ_d;
    logic [15:0] count_q, count_d;
    logic        push, pop;
    entry_t      head;

    assign head          = mem_q[rd_ptr_q];
    assign bus.in_ready  = !reset && (occ_q != 2'd2);
    assign bus.out_valid = !reset && (occ_q != 2'd0);
    assign bus.inst      = reset ? 32'h0 : head.inst;
    assign bus.err       = reset ? 1'b0  : head.err;
    assign bus.count     = reset ? 16'h0 : count_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{inst: enc_inst, err: enc_err};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            count_d  = count_q + 16'd1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment; storage is cleared too so
        // an empty FIFO never exposes stale words on inst after reset.
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            count_q  <= 16'h0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_encode.sv
// Scoreboard bench for encode: stimulus pushes expected {inst, err}, a negedge
// monitor pops and compares on every output transfer.
module tb_encode;
    logic clk;
    logic reset;
    encode_if bus ();

    encode dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ENCODE_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          exp_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, away from state updates.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("inst", bus.inst, e.inst);
                check("err", {31'd0, bus.err}, {31'd0, e.err});
                check("count_before_pop", {16'd0, bus.count}, exp_count);
            end
            exp_count++;
        end
    end

    // All main-thread driving and direct checks happen 2 time units after posedge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic [31:0] exp_inst, input logic exp_err);
        bit done = 1'b0;
        bus.opcode = op;  bus.rd = rd;  bus.rs1 = rs1;  bus.rs2 = rs2;
        bus.funct3 = f3;  bus.funct7 = f7;  bus.imm = imm;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.in_ready) begin
                sb.push_back('{inst: exp_inst, err: exp_err});
                done = 1'b1;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;  bus.out_ready = 1'b0;
        bus.opcode = '0;  bus.rd = '0;  bus.rs1 = '0;  bus.rs2 = '0;
        bus.funct3 = '0;  bus.funct7 = '0;  bus.imm = '0;
        repeat (3) tick();
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_count", {16'd0, bus.count}, 32'd0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // ADDI x1,x0,5: visible one cycle after accept.
        bus.out_ready = 1'b1;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
        check("lat_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("lat_inst", bus.inst, 32'h00500093);
        tick();
        check("count_one", {16'd0, bus.count}, 32'd1);

        // Back-to-back directed words, consumer always ready.
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0);
        send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 1'b0);
        send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd16, 32'h00208863, 1'b0);
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 32'h001000EF, 1'b0);
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        // Out-of-range immediates: err only with the range check, word still emitted.
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 32'h80000093, RC);
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h00208163, RC);
        drain();
        check("count_ten", {16'd0, bus.count}, 32'd10);

        // Stall consumer: third word must wait for a free slot.
        bus.out_ready = 1'b0;
        fork
            begin
                send(7'b0110011, 5'd10, 5'd11, 5'd12, 3'd7, 7'h20, 32'd0, 32'h40C5F533, 1'b0);
                send(7'b0110011, 5'd4,  5'd5,  5'd6,  3'd1, 7'h00, 32'd0, 32'h00629233, 1'b0);
                send(7'b0010011, 5'd7,  5'd8,  5'd0,  3'd4, 7'd0,  32'h7FF, 32'h7FF44393, 1'b0);
            end
            begin
                tick();
                tick();
                check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
                check("full_out_valid", {31'd0, bus.out_valid}, 32'd1);
                check("full_head", bus.inst, 32'h40C5F533);
                tick();
                check("stall_head_stable", bus.inst, 32'h40C5F533);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("count_thirteen", {16'd0, bus.count}, 32'd13);

        // Reset with two words buffered discards them.
        bus.out_ready = 1'b0;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00100093, 1'b0);
        send(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h00200113, 1'b0);
        check("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
        reset = 1'b1;
        sb.delete();
        tick();
        exp_count = 0;
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_count", {16'd0, bus.count}, 32'd0);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rel_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rel_count", {16'd0, bus.count}, 32'd0);
        #1;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
        drain();
        check("final_count", {16'd0, bus.count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/encode.md
ENCODE -- requirements
Module: encode

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  request carries fields to encode.
REQ-004 in_ready  output  1  encoder can accept; transfer when in_valid && in_ready.
REQ-005 opcode  input  7  major opcode; selects format.
REQ-006 rd, rs1, rs2  input  5 each  register fields.
REQ-007 funct3  input  3; funct7  input  7  function fields.
REQ-008 imm  input  32  architectural immediate (byte offset for B/J, full value for U).
REQ-009 out_valid  output  1  inst holds an encoded word.
REQ-010 out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
REQ-011 inst  output  32  encoded RV32I instruction word.
REQ-012 err  output  1  immediate not representable in selected format (see Configuration).
REQ-013 count  output  16  number of words transferred out.

Function
REQ-014 Format by opcode: 0110011 R; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; all others I.
REQ-015 R = {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-016 I = {imm[11:0], rs1, funct3, rd, opcode}.
REQ-017 S = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-018 B = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-019 U = {imm[31:12], rd, opcode}.
REQ-020 J = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-021 Encoding computed combinationally at input; stored with err into 2-entry FIFO of {inst, err}.
REQ-022 in_ready = FIFO not full; independent of in_valid.
REQ-023 out_valid = FIFO not empty; inst/err driven from head entry, stable while out_valid && !out_ready.
REQ-024 Latency: word accepted in cycle N appears on out_valid/inst in cycle N+1 when FIFO was empty.
REQ-025 FIFO order strictly FIFO; read/write pointers 1 bit, wrap after entry 1.
REQ-026 Simultaneous push and pop with 1 entry: occupancy stays 1, head advances to new word next cycle.
REQ-027 Full (2 entries): in_ready=0; pop frees one slot, in_ready=1 next cycle.
REQ-028 Pop when empty and push when full impossible by handshake; no state change from ignored strobes.
REQ-029 count increments by 1 per output transfer; wraps 0xFFFF -> 0x0000.

Reset
REQ-030 While reset high: FIFO emptied, out_valid=0, in_ready=0, count=0, err=0, inst=0x00000000.
REQ-031 First cycle after reset deasserts: in_ready=1; reset mid-transfer discards all buffered words.

Configuration
REQ-032 Macro ENCODE_RANGE_CHECK_EN defined: err=1 when I/S imm not sign-extension of imm[11:0]; B not sign-extension of imm[12:0] or imm[0]=1; J not sign-extension of imm[20:0] or imm[0]=1; U imm[11:0]!=0; R never.
REQ-033 Macro undefined: err tied 0, no check logic; encoding unchanged (out-of-range bits silently dropped).
REQ-034 err never blocks a transfer; word still encoded and emitted.

Verification
REQ-035 ADDI x1,x0,5 (op 0010011, rd=1, f3=0, imm=5), out_ready=1 -> inst 0x00500093 one cycle later, err=0, count=1.
REQ-036 ADD x3,x1,x2 -> 0x002081B3; SW x2,8(x1) -> 0x0020A423; LUI x5,0x12345000 -> 0x123452B7.
REQ-037 BEQ x1,x2,imm=16 -> 0x00208863; JAL x1,imm=0x800 -> 0x001000EF.
REQ-038 out_ready=0, push 3 words back-to-back -> in_ready low after 2nd accept; release -> 3 words in order, count=3.
REQ-039 ENCODE_RANGE_CHECK_EN: ADDI imm=0x800 -> err=1; BEQ imm=3 -> err=1; without macro same stimulus -> err=0.
REQ-040 Assert reset with 2 words buffered -> next cycle out_valid=0, count=0; then in_ready=1 after release.
